// File: rtl/arb_client.sv
// ---------------------------------------------------------------------------
// arb_client
//
// Client-side requester for a 3-way one-hot arbiter. One instance sits in
// each requester slot. Outgoing words are buffered in a small FIFO. The
// client raises a request, waits for its grant bit, and then drives a burst
// of at most MAX_BURST words onto the shared bus. After the burst it drops
// the request and waits for the grant to fall, so that the arbiter can hand
// ownership to another client.
//
// Parameters
//   DATA_WIDTH : bus and FIFO word width
//   FIFO_DEPTH : FIFO entries (power of 2, at least 2)
//   MAX_BURST  : maximum words transferred per ownership (at least 1)
//
// Ports
//   i_clk       : single clock, rising edge
//   i_res_n     : synchronous active-low reset
//   i_wr_en     : push i_wr_data into the FIFO
//   i_wr_data   : word to queue
//   o_full      : FIFO count equals FIFO_DEPTH (combinational)
//   o_empty     : FIFO count is zero (combinational)
//   o_overflow  : sticky flag, set by a write while full, cleared by reset
//   o_req       : registered request to the arbiter
//   i_grant     : this client's bit of the arbiter's registered grant
//   o_bus_valid : registered, high for one cycle per transferred word
//   o_bus_data  : registered, holds the last transferred word
// ---------------------------------------------------------------------------
module arb_client #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_res_n,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic                  o_req,
    input  logic                  i_grant,
    output logic                  o_bus_valid,
    output logic [DATA_WIDTH-1:0] o_bus_data
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] COUNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [BW-1:0] BURST_ONE   = BW'(1);
    localparam logic [BW-1:0] BURST_FINAL = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BURST   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    // Requester state
    state_t                r_state;
    logic                  r_req;
    logic                  r_busValid;
    logic [DATA_WIDTH-1:0] r_busData;
    logic [BW-1:0]         r_burstCnt;

    // Combinational decisions for the current edge
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wrAccept;
    logic                  w_beat;
    logic                  w_lastBeat;
    logic                  w_burstClear;
    logic                  w_reqNext;
    state_t                w_stateNext;

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);

    // Room is judged on the count before the edge, so a pop in the same
    // cycle never frees a slot for a write while full.
    assign w_wrAccept = i_wr_en && !w_full;

    // The burst ends either on the cap or when the head is the only queued
    // word; a write landing in the same cycle does not extend the burst.
    assign w_lastBeat = (r_burstCnt == BURST_FINAL) || (r_count == COUNT_ONE);

    // Next-state and request logic. A beat happens only while owning the
    // bus (WAIT or BURST with grant high). Losing grant in BURST keeps the
    // request up and the burst count intact, so the burst resumes later.
    always_comb begin
        w_stateNext  = r_state;
        w_reqNext    = r_req;
        w_beat       = 1'b0;
        w_burstClear = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_reqNext = 1'b0;
                if (!w_empty) begin
                    w_reqNext    = 1'b1;
                    w_burstClear = 1'b1;
                    w_stateNext  = WAIT;
                end
            end
            WAIT, BURST: begin
                if (i_grant && !w_empty) begin
                    w_beat = 1'b1;
                    if (w_lastBeat) begin
                        w_reqNext   = 1'b0;
                        w_stateNext = RELEASE;
                    end else begin
                        w_reqNext   = 1'b1;
                        w_stateNext = BURST;
                    end
                end else if (!i_grant) begin
                    w_reqNext   = 1'b1;
                    w_stateNext = WAIT;
                end
            end
            RELEASE: begin
                w_reqNext = 1'b0;
                if (!i_grant) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_reqNext   = 1'b0;
                w_stateNext = IDLE;
            end
        endcase
    end

    // Word storage has no reset: discarding queued words on reset is done
    // purely by clearing the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_wrAccept) begin
            r_mem[r_wrPtr] <= i_wr_data;
        end
    end

    // FIFO pointers, occupancy count and the sticky overflow flag.
    // Pointers wrap naturally because the depth is a power of 2.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_beat) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (w_wrAccept && !w_beat) begin
                r_count <= r_count + COUNT_ONE;
            end else if (!w_wrAccept && w_beat) begin
                r_count <= r_count - COUNT_ONE;
            end
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // State register, request, burst counter and bus outputs. bus_valid is
    // a one-cycle pulse per beat; bus_data holds the last word between beats.
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_busValid <= 1'b0;
            r_busData  <= '0;
            r_burstCnt <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_req      <= w_reqNext;
            r_busValid <= w_beat;
            if (w_beat) begin
                r_busData  <= r_mem[r_rdPtr];
                r_burstCnt <= r_burstCnt + BURST_ONE;
            end else if (w_burstClear) begin
                r_burstCnt <= '0;
            end
        end
    end

    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overflow  = r_overflow;
    assign o_req       = r_req;
    assign o_bus_valid = r_busValid;
    assign o_bus_data  = r_busData;

endmodule

// File: tb/tb_arb_client.sv
// ---------------------------------------------------------------------------
// tb_arb_client
//
// Directed bench for arb_client with default parameters (8-bit words,
// 4-entry FIFO, bursts of at most 4). A registered model arbiter grants one
// cycle after it sees req, gated by grantEnable so the bench can withhold or
// drop the grant. Each step drives inputs just after an edge, advances one
// edge and compares req / bus_valid / bus_data with hand-derived values.
// ---------------------------------------------------------------------------
module tb_arb_client;

    logic       clk = 1'b0;
    logic       resN;
    logic       wrEn;
    logic [7:0] wrData;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       req;
    logic       grant = 1'b0;
    logic       busValid;
    logic [7:0] busData;
    logic       grantEnable;

    int vectors = 0;
    int miscompares = 0;

    arb_client #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .MAX_BURST (4)
    ) dut (
        .i_clk      (clk),
        .i_res_n    (resN),
        .i_wr_en    (wrEn),
        .i_wr_data  (wrData),
        .o_full     (full),
        .o_empty    (empty),
        .o_overflow (overflow),
        .o_req      (req),
        .i_grant    (grant),
        .o_bus_valid(busValid),
        .o_bus_data (busData)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Model arbiter: registers this client's grant one cycle after req
    always @(posedge clk) begin
        grant <= (req === 1'b1) && grantEnable;
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the write port and the arbiter's willingness to grant
    task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic ge);
        wrEn        = wr;
        wrData      = data;
        grantEnable = ge;
    endtask

    // One comparison: counts the vector and reports any miscompare
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive inputs for the coming edge, take the edge, check the bus side
    task automatic step(input string tag, input logic wr, input logic [7:0] data, input logic ge,
                        input logic eReq, input logic eValid, input logic [7:0] eData);
        applyStimulus(wr, data, ge);
        tick();
        checkOutput({tag, "_req"},   {31'd0, req},      {31'd0, eReq});
        checkOutput({tag, "_valid"}, {31'd0, busValid}, {31'd0, eValid});
        checkOutput({tag, "_data"},  {24'd0, busData},  {24'd0, eData});
    endtask

    initial begin
        // Reset held for two edges while a write is attempted
        resN = 1'b0;
        applyStimulus(1'b1, 8'h77, 1'b1);
        tick();
        tick();
        checkOutput("rst_req",      {31'd0, req},      32'd0);
        checkOutput("rst_valid",    {31'd0, busValid}, 32'd0);
        checkOutput("rst_data",     {24'd0, busData},  32'd0);
        checkOutput("rst_empty",    {31'd0, empty},    32'd1);
        checkOutput("rst_full",     {31'd0, full},     32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        resN = 1'b1;
        step("idle0", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step("idle1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);

        // Single word 0xA5: req at edge 1, beat at edge 3, idle again at 5
        step("single_e0", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("single_e0_empty", {31'd0, empty}, 32'd0);
        step("single_e1", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        step("single_e2", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        step("single_e3", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5);
        step("single_e4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5);
        step("single_e5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5);
        checkOutput("single_e5_empty", {31'd0, empty}, 32'd1);
        step("single_e6", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5);

        // Burst cap: six words split into 4 + 2 with req low for 3 cycles
        step("burst_e0",  1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'hA5);
        step("burst_e1",  1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'hA5);
        step("burst_e2",  1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 8'hA5);
        step("burst_e3",  1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h01);
        step("burst_e4",  1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02);
        step("burst_e5",  1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 8'h03);
        step("burst_e6",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04);
        step("burst_e7",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04);
        step("burst_e8",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04);
        step("burst_e9",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04);
        step("burst_e10", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h04);
        step("burst_e11", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05);
        step("burst_e12", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h06);
        step("burst_e13", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h06);
        checkOutput("burst_e13_empty", {31'd0, empty}, 32'd1);
        step("burst_e14", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h06);
        step("burst_e15", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h06);

        // Full and overflow: five writes without grant, then drain four
        step("ovf_e0", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h06);
        step("ovf_e1", 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h06);
        step("ovf_e2", 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h06);
        checkOutput("ovf_e2_full", {31'd0, full}, 32'd0);
        step("ovf_e3", 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h06);
        checkOutput("ovf_e3_full",     {31'd0, full},     32'd1);
        checkOutput("ovf_e3_overflow", {31'd0, overflow}, 32'd0);
        step("ovf_e4", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h06);
        checkOutput("ovf_e4_full",     {31'd0, full},     32'd1);
        checkOutput("ovf_e4_overflow", {31'd0, overflow}, 32'd1);
        step("ovf_e5",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h06);
        step("ovf_e6",  1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11);
        checkOutput("ovf_e6_full", {31'd0, full}, 32'd0);
        step("ovf_e7",  1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22);
        step("ovf_e8",  1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33);
        step("ovf_e9",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44);
        step("ovf_e10", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44);
        checkOutput("ovf_e10_empty", {31'd0, empty}, 32'd1);
        step("ovf_e11", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44);
        checkOutput("ovf_e11_sticky", {31'd0, overflow}, 32'd1);

        // Single reset edge clears the sticky overflow and bus_data
        resN = 1'b0;
        step("rst2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("rst2_overflow", {31'd0, overflow}, 32'd0);
        resN = 1'b1;
        step("rst2_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);

        // Grant lost for two cycles after beat 2, then beats 3 and 4 resume
        step("loss_e0", 1'b1, 8'hC1, 1'b1, 1'b0, 1'b0, 8'h00);
        step("loss_e1", 1'b1, 8'hC2, 1'b1, 1'b1, 1'b0, 8'h00);
        step("loss_e2", 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h00);
        step("loss_e3", 1'b1, 8'hC4, 1'b1, 1'b1, 1'b1, 8'hC1);
        step("loss_e4", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC2);
        step("loss_e5", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC2);
        step("loss_e6", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC2);
        step("loss_e7", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3);
        step("loss_e8", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hC4);
        step("loss_e9", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC4);
        checkOutput("loss_e9_empty", {31'd0, empty}, 32'd1);
        step("loss_e10", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC4);
        step("loss_e11", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC4);

        // Reset after beat 1 of 3: queue discarded, no residual beats
        step("midrst_e0", 1'b1, 8'hD1, 1'b1, 1'b0, 1'b0, 8'hC4);
        step("midrst_e1", 1'b1, 8'hD2, 1'b1, 1'b1, 1'b0, 8'hC4);
        step("midrst_e2", 1'b1, 8'hD3, 1'b1, 1'b1, 1'b0, 8'hC4);
        step("midrst_e3", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hD1);
        resN = 1'b0;
        step("midrst_e4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("midrst_e4_empty", {31'd0, empty}, 32'd1);
        resN = 1'b1;
        step("midrst_e5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step("midrst_e6", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step("midrst_e7", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step("midrst_e8", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("midrst_e8_empty", {31'd0, empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arb_client.md
# arb_client

Client-side requester for the 3-way one-hot arbiter; one instance per requester slot. Buffers outgoing words in a small FIFO, raises `req`, waits for its `grant` bit, and drives a burst of at most `MAX_BURST` words onto the shared bus. It then drops `req` and waits for `grant` to fall, so the arbiter can hand over to another client.

## Interface

- `DATA_WIDTH`, default 8: bus and FIFO word width.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `MAX_BURST`, default 4: maximum words per ownership; must be at least 1.

- `clk`: input, 1 bit. Single clock; all logic on the rising edge.
- `res_n`: input, 1 bit. Reset, synchronous and active-low.
- `wr_en`: input, 1 bit. Push `wr_data` into the FIFO.
- `wr_data`: input, `DATA_WIDTH` bits. Word to queue.
- `full`: output, 1 bit. FIFO count equals `FIFO_DEPTH`; combinational from count.
- `empty`: output, 1 bit. FIFO count is 0; combinational from count.
- `overflow`: output, 1 bit. Sticky; set by a write while full; cleared only by reset.
- `req`: output, 1 bit. Registered request to the arbiter.
- `grant`: input, 1 bit. This client's bit of the arbiter's registered one-hot grant.
- `bus_valid`: output, 1 bit. Registered; high for one cycle per transferred word.
- `bus_data`: output, `DATA_WIDTH` bits. Registered; holds the last transferred word.

## Operation

- Reset (`res_n`=0 at an edge) forces the following, regardless of state, including mid-burst:
  - FIFO pointers and count to 0, and `overflow`=0.
  - `req`=0, `bus_valid`=0, `bus_data`=0, burst count=0, state IDLE.
  - Queued words are discarded.
- FIFO write side:
  - A write is accepted when `wr_en`=1 and count<`FIFO_DEPTH` before the edge.
  - A write while full is dropped and sets `overflow`.
  - A pop in the same cycle does not make room for a write that cycle.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A simultaneous accepted write and pop leaves count unchanged.
- State machine, using values sampled at the edge:
  - IDLE: `req`=0. If count>0, set `req`<=1, burst count<=0, go to WAIT.
  - WAIT: `req`=1. If `grant`=1, perform a beat and go to BURST (or RELEASE if the beat is the last).
  - BURST: if `grant`=1, perform a beat. If `grant`=0 (grant lost mid-burst), do not pop, keep `req`=1, keep burst count, and go to WAIT.
  - RELEASE: `req`=0, no pops. When `grant`=0, go to IDLE.
- Beat:
  - Pop the FIFO head: `bus_data`<=head, `bus_valid`<=1, burst count +1.
  - The beat is the last if burst count+1=`MAX_BURST` or count=1 before the edge (a write in the same cycle does not extend the burst).
  - On the last beat, `req`<=0 and go to RELEASE.
- `bus_valid`<=0 on every edge without a beat.
- `bus_data` holds its value when no beat occurs.
- Burst count width is clog2(`MAX_BURST`+1); it is never compared past `MAX_BURST`.

## Timing

Edge numbering starts with the edge that accepts a write into an empty FIFO, with the arbiter idle.

- Edge 0: write accepted; `empty`=0 after edge 0.
- Edge 1: `req`=1.
- Edge 2: arbiter registers `grant`=1.
- Edge 3: first beat; `bus_valid`=1.
- For a burst of N words:
  - Beats occur on edges 3 … N+2, back-to-back with no bubbles while `grant` stays high.
  - `req` falls on edge N+2.
  - The arbiter drops `grant` at edge N+3.
  - The client reaches IDLE at edge N+4 and may re-raise `req` at edge N+5.
- Write-to-first-beat latency is 3 edges with an uncontended arbiter. Each contended cycle adds 1.
- `req` is low for at least 2 cycles between ownerships.

## Test plan

- Reset values: hold `res_n`=0 for 2 cycles with `wr_en`=1 -> `req`=0, `bus_valid`=0, `bus_data`=0, `empty`=1, `full`=0, `overflow`=0.
- Single word, using a model arbiter that grants 1 cycle after `req`: write 0xA5 -> `req` high at edge 1, one `bus_valid` pulse with 0xA5 at edge 3, `req` low at edge 3, back in IDLE at edge 5.
- Burst cap, with `MAX_BURST`=4: write 0x01–0x06 back-to-back -> first ownership transfers 0x01–0x04 on 4 consecutive cycles. `req` then stays low ≥2 cycles, and a second ownership transfers 0x05 and 0x06.
- Full and overflow: 5 writes with no grant -> `full`=1 after the 4th write, 5th write dropped, `overflow`=1. After granting, exactly 4 words come out, in order.
- Grant loss mid-burst: queue 4 words and drop `grant` for 2 cycles after beat 2 -> no `bus_valid` during the gap and `req` stays 1. Beats 3 and 4 resume when `grant` returns; total 4 words with no duplicates.
- Reset mid-burst: assert `res_n`=0 after beat 1 of 3 -> next cycle `req`=0, `bus_valid`=0, `empty`=1. After release, no residual beats occur.
